// File: rtl/satagtx_rst_seq.sv
// SATA GTX/GTP reset sequencer: sequences transceiver reset, waits for PLL/DCM lock and
// reset-done, then releases the link layer; restarts on lock loss, timeout or soft reset.
module satagtx_rst_seq #(
   parameter int unsigned C_GTXRST_CYCLES  = 16,
   parameter int unsigned C_STABLE_CYCLES  = 1024,
   parameter int unsigned C_TIMEOUT_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       plllkdet,
   input  logic       dcm_locked,
   input  logic       resetdone,
   input  logic       soft_rst,
   output logic       gtxreset,
   output logic       link_rst_n,
   output logic       ready,
   output logic [7:0] retry_cnt,
   output logic [2:0] state
);

   localparam int unsigned CNT_W = 17;
   localparam logic [CNT_W-1:0] GTX_LAST    = CNT_W'(C_GTXRST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(C_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(C_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_GTX_RST   = 3'd1,
      ST_WAIT_PLL  = 3'd2,
      ST_WAIT_DCM  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_READY     = 3'd5
   } state_t;

   state_t           cur_st, nxt_st;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] tmo, tmo_nxt;
   logic [7:0]       retry_nxt;
   logic [2:0]       sync1, sync2;
   logic             pll_s, dcm_s, done_s;
   logic             in_wait, lock_loss, timeout;

   // Two-flop synchronizers for the clk-asynchronous status inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
      end else begin
         sync1 <= {resetdone, dcm_locked, plllkdet};
         sync2 <= sync1;
      end
   end

   assign pll_s  = sync2[0];
   assign dcm_s  = sync2[1];
   assign done_s = sync2[2];

   assign in_wait   = (cur_st == ST_WAIT_PLL) || (cur_st == ST_WAIT_DCM) ||
                      (cur_st == ST_WAIT_DONE);
   assign lock_loss = (!pll_s && ((cur_st == ST_WAIT_DCM) || (cur_st == ST_WAIT_DONE) ||
                                  (cur_st == ST_READY))) ||
                      (!dcm_s && ((cur_st == ST_WAIT_DONE) || (cur_st == ST_READY)));
   assign timeout   = in_wait && (tmo == TMO_LAST);

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st     <= ST_RESET;
         cnt        <= '0;
         tmo        <= '0;
         retry_cnt  <= 8'd0;
         gtxreset   <= 1'b1;
         link_rst_n <= 1'b0;
         ready      <= 1'b0;
      end else begin
         cur_st     <= nxt_st;
         cnt        <= cnt_nxt;
         tmo        <= tmo_nxt;
         retry_cnt  <= retry_nxt;
         gtxreset   <= (nxt_st == ST_RESET) || (nxt_st == ST_GTX_RST);
         link_rst_n <= (nxt_st == ST_READY);
         ready      <= (nxt_st == ST_READY);
      end
   end

   // Next state: forward progress first, then restart events override by priority
   always_comb begin
      nxt_st    = cur_st;
      cnt_nxt   = cnt;
      tmo_nxt   = in_wait ? tmo + CNT_W'(1) : tmo;
      retry_nxt = retry_cnt;

      case (cur_st)
         ST_RESET: begin
            nxt_st  = ST_GTX_RST;
            cnt_nxt = '0;
         end
         ST_GTX_RST: begin
            if (cnt == GTX_LAST) begin
               nxt_st  = ST_WAIT_PLL;
               cnt_nxt = '0;
               tmo_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_WAIT_PLL: begin
            if (!pll_s) begin
               cnt_nxt = '0;
            end else if (cnt == STABLE_LAST) begin
               nxt_st  = ST_WAIT_DCM;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_WAIT_DCM:  if (dcm_s)  nxt_st = ST_WAIT_DONE;
         ST_WAIT_DONE: if (done_s) nxt_st = ST_READY;
         ST_READY:     nxt_st = ST_READY;
         default: begin
            nxt_st  = ST_RESET;
            cnt_nxt = '0;
         end
      endcase

      if (soft_rst) begin
         nxt_st  = ST_GTX_RST;
         cnt_nxt = '0;
      end else if (lock_loss || timeout) begin
         nxt_st  = ST_GTX_RST;
         cnt_nxt = '0;
         if (retry_cnt != 8'hFF) retry_nxt = retry_cnt + 8'd1;
      end
   end

   assign state = cur_st;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Directed self-checking bench for satagtx_rst_seq (GTXRST=4, STABLE=8, TIMEOUT=32).
module tb_satagtx_rst_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       plllkdet = 1'b1;
   logic       dcm_locked = 1'b1;
   logic       resetdone = 1'b1;
   logic       soft_rst = 1'b0;
   logic       gtxreset, link_rst_n, ready;
   logic [7:0] retry_cnt;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   satagtx_rst_seq #(
      .C_GTXRST_CYCLES (4),
      .C_STABLE_CYCLES (8),
      .C_TIMEOUT_CYCLES(32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .plllkdet  (plllkdet),
      .dcm_locked(dcm_locked),
      .resetdone (resetdone),
      .soft_rst  (soft_rst),
      .gtxreset  (gtxreset),
      .link_rst_n(link_rst_n),
      .ready     (ready),
      .retry_cnt (retry_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Assert reset, then release mid-cycle so the next rising edge is edge 1
   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #22;
      n_checks++; if (gtxreset !== 1'b1)   begin n_fail++; $display("FAIL reset_gtxreset got %b exp 1", gtxreset); end
      n_checks++; if (link_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_link_rst_n got %b exp 0", link_rst_n); end
      n_checks++; if (ready !== 1'b0)      begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
      n_checks++; if (retry_cnt !== 8'd0)  begin n_fail++; $display("FAIL reset_retry got %0d exp 0", retry_cnt); end
      n_checks++; if (state !== 3'd0)      begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
   endtask

   // gtxreset high after edges 1..4 (plus the RESET cycle), ready from edge 15
   task automatic test_bringup();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         step(1);
         n_checks++;
         if (gtxreset !== (k <= 4)) begin
            n_fail++; $display("FAIL bringup_gtxreset edge %0d got %b exp %b", k, gtxreset, (k <= 4));
         end
         n_checks++;
         if (ready !== (k >= 15)) begin
            n_fail++; $display("FAIL bringup_ready edge %0d got %b exp %b", k, ready, (k >= 15));
         end
         if (k == 5) begin
            n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL bringup_wait_pll got %0d exp 2", state); end
         end
      end
      n_checks++; if (link_rst_n !== 1'b1) begin n_fail++; $display("FAIL bringup_link got %b exp 1", link_rst_n); end
      n_checks++; if (state !== 3'd5)      begin n_fail++; $display("FAIL bringup_state got %0d exp 5", state); end
      n_checks++; if (retry_cnt !== 8'd0)  begin n_fail++; $display("FAIL bringup_retry got %0d exp 0", retry_cnt); end
   endtask

   // One-cycle PLL drop seen at stable count 5: counter restarts, ready moves 15 -> 21
   task automatic test_pll_glitch();
      do_reset();
      for (int k = 1; k <= 22; k++) begin
         step(1);
         if (k == 8) plllkdet = 1'b0;
         if (k == 9) plllkdet = 1'b1;
         n_checks++;
         if (ready !== (k >= 21)) begin
            n_fail++; $display("FAIL glitch_ready edge %0d got %b exp %b", k, ready, (k >= 21));
         end
      end
      n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_retry got %0d exp 0", retry_cnt); end
   endtask

   task automatic test_lock_loss();
      dcm_locked = 1'b0;
      step(1);
      dcm_locked = 1'b1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lockloss_ready_e1 got %b exp 1", ready); end
      step(1);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lockloss_ready_e2 got %b exp 1", ready); end
      step(1);
      n_checks++; if (ready !== 1'b0)      begin n_fail++; $display("FAIL lockloss_ready got %b exp 0", ready); end
      n_checks++; if (gtxreset !== 1'b1)   begin n_fail++; $display("FAIL lockloss_gtxreset got %b exp 1", gtxreset); end
      n_checks++; if (link_rst_n !== 1'b0) begin n_fail++; $display("FAIL lockloss_link got %b exp 0", link_rst_n); end
      n_checks++; if (retry_cnt !== 8'd1)  begin n_fail++; $display("FAIL lockloss_retry got %0d exp 1", retry_cnt); end
      step(13);
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lockloss_early_ready got %b exp 0", ready); end
      step(1);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lockloss_reready got %b exp 1", ready); end
   endtask

   task automatic test_soft_rst();
      soft_rst = 1'b1;
      step(1);
      soft_rst = 1'b0;
      n_checks++; if (gtxreset !== 1'b1)  begin n_fail++; $display("FAIL soft_gtxreset got %b exp 1", gtxreset); end
      n_checks++; if (state !== 3'd1)     begin n_fail++; $display("FAIL soft_state got %0d exp 1", state); end
      n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL soft_retry got %0d exp 1", retry_cnt); end
      step(13);
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL soft_early_ready got %b exp 0", ready); end
      step(1);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL soft_reready got %b exp 1", ready); end
      // Held request pins GTX_RST with cnt=0; full GTXRST count follows release
      soft_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1);
         n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL softhold_state k=%0d got %0d exp 1", k, state); end
      end
      soft_rst = 1'b0;
      step(3);
      n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL softhold_tail got %0d exp 1", state); end
      step(1);
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL softhold_exit got %0d exp 2", state); end
   endtask

   task automatic test_async_reset();
      resetdone = 1'b0;
      soft_rst  = 1'b1;
      step(1);
      soft_rst  = 1'b0;
      step(13);
      n_checks++; if (state !== 3'd4)     begin n_fail++; $display("FAIL async_pre_state got %0d exp 4", state); end
      n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL async_pre_retry got %0d exp 1", retry_cnt); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (gtxreset !== 1'b1)   begin n_fail++; $display("FAIL async_gtxreset got %b exp 1", gtxreset); end
      n_checks++; if (link_rst_n !== 1'b0) begin n_fail++; $display("FAIL async_link got %b exp 0", link_rst_n); end
      n_checks++; if (ready !== 1'b0)      begin n_fail++; $display("FAIL async_ready got %b exp 0", ready); end
      n_checks++; if (state !== 3'd0)      begin n_fail++; $display("FAIL async_state got %0d exp 0", state); end
      n_checks++; if (retry_cnt !== 8'd0)  begin n_fail++; $display("FAIL async_retry got %0d exp 0", retry_cnt); end
   endtask

   // resetdone stuck low: restart edges at 37 + 36*n, saturating after 255 loops
   task automatic test_timeout();
      resetdone = 1'b0;
      do_reset();
      step(36);
      n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL tmo_before got %0d exp 0", retry_cnt); end
      step(1);
      n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL tmo_first got %0d exp 1", retry_cnt); end
      n_checks++; if (state !== 3'd1)     begin n_fail++; $display("FAIL tmo_first_state got %0d exp 1", state); end
      n_checks++; if (gtxreset !== 1'b1)  begin n_fail++; $display("FAIL tmo_first_gtx got %b exp 1", gtxreset); end
      step(35);
      n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL tmo_period got %0d exp 1", retry_cnt); end
      step(1);
      n_checks++; if (retry_cnt !== 8'd2) begin n_fail++; $display("FAIL tmo_second got %0d exp 2", retry_cnt); end
      step(9072);
      n_checks++; if (retry_cnt !== 8'd254) begin n_fail++; $display("FAIL tmo_254 got %0d exp 254", retry_cnt); end
      step(36);
      n_checks++; if (retry_cnt !== 8'd255) begin n_fail++; $display("FAIL tmo_255 got %0d exp 255", retry_cnt); end
      step(72);
      n_checks++; if (retry_cnt !== 8'd255) begin n_fail++; $display("FAIL tmo_sat got %0d exp 255", retry_cnt); end
      n_checks++; if (state !== 3'd1)       begin n_fail++; $display("FAIL tmo_sat_state got %0d exp 1", state); end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_pll_glitch();
      test_lock_loss();
      test_soft_rst();
      test_async_reset();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/satagtx_rst_seq.md
# satagtx_rst_seq

Reset sequencer for the SATA GTX/GTP tile; sits directly downstream of the tile clocking block. Consumes the transceiver PLL lock detect, the user-clock DCM/PLL lock, and the transceiver reset-done status. Produces a sequenced transceiver reset and a link-layer reset release, re-running the sequence on loss of lock, timeout or software request. Runs on a free-running clock that is independent of the recovered and user clocks.

## Interface
- C_GTXRST_CYCLES, 16: cycles `gtxreset` is held high per sequence pass; legal range 1..65535.
- C_STABLE_CYCLES, 1024: consecutive synchronized cycles of `plllkdet` high required to accept PLL lock; legal range 1..65535.
- C_TIMEOUT_CYCLES, 65536: cycles allowed from entry to WAIT_PLL until READY; legal range 2..131071.

Ports:
- clk  in  1  free-running sequencer clock.
- rst_n  in  1  asynchronous active-low reset.
- plllkdet  in  1  transceiver PLL lock detect; asynchronous to clk.
- dcm_locked  in  1  user-clock DCM/PLL locked from the clock block; asynchronous to clk.
- resetdone  in  1  transceiver TX/RX reset done (AND of both); asynchronous to clk.
- soft_rst  in  1  synchronous one-cycle request to restart the sequence.
- gtxreset  out  1  transceiver reset, active high.
- link_rst_n  out  1  link/transport reset, active low.
- ready  out  1  sequence complete.
- retry_cnt  out  8  saturating count of lock-loss and timeout restarts.
- state  out  3  current state encoding, for debug.

## Operation
- Each asynchronous input passes through a two-flop synchronizer, reset to 0. This yields pll_s, dcm_s and done_s.
- State encoding: RESET=0, GTX_RST=1, WAIT_PLL=2, WAIT_DCM=3, WAIT_DONE=4, READY=5. Codes 6 and 7 go to RESET.
- Two counters:
  - cnt: 17 bits, shared phase counter.
  - tmo: 17 bits, timeout counter.
- Transitions:
  - RESET: go to GTX_RST on the next clock edge; cnt=0.
  - GTX_RST: cnt increments each cycle. At cnt=C_GTXRST_CYCLES-1, go to WAIT_PLL and clear cnt and tmo.
  - WAIT_PLL: if pll_s=1, cnt increments; if pll_s=0, cnt clears. At cnt=C_STABLE_CYCLES-1 with pll_s=1, go to WAIT_DCM.
  - WAIT_DCM: if dcm_s=1, go to WAIT_DONE.
  - WAIT_DONE: if done_s=1, go to READY.
  - READY: stay while pll_s=1 and dcm_s=1.
- tmo increments in WAIT_PLL, WAIT_DCM and WAIT_DONE. It holds in all other states.
- Restart events:
  - Lock loss: pll_s=0 in WAIT_DCM, WAIT_DONE or READY, or dcm_s=0 in WAIT_DONE or READY. Go to GTX_RST, cnt=0, retry_cnt+1.
  - Timeout: tmo=C_TIMEOUT_CYCLES-1 in a wait state. Go to GTX_RST, cnt=0, retry_cnt+1.
  - Soft reset: soft_rst=1 in any state. Go to GTX_RST, cnt=0, retry_cnt unchanged.
- Priority when events coincide: soft_rst, then lock loss, then timeout, then forward progress. A coincident timeout and lock loss increments retry_cnt once.
- retry_cnt saturates at 255. It is cleared only by rst_n.
- Outputs are registered and decoded from the next state:
  - gtxreset=1 in RESET and GTX_RST.
  - link_rst_n=1 and ready=1 only in READY.

## Timing
- Reset values: gtxreset=1, link_rst_n=0, ready=0, retry_cnt=0, state=0, cnt=0, tmo=0, synchronizers=0.
- Input latency: 2 clk cycles of synchronizer delay, plus 1 registered-output cycle.
- gtxreset stays high for exactly C_GTXRST_CYCLES+1 cycles after the first edge following rst_n deassertion. This includes the RESET cycle.
- Minimum time from WAIT_PLL entry to ready=1, with all inputs already high: C_STABLE_CYCLES+2 cycles.
- Lock loss in READY: ready=0, link_rst_n=0 and gtxreset=1 all appear 3 cycles after the plllkdet/dcm_locked falling edge.
- rst_n assertion at any point forces the reset values immediately, without waiting for a clock edge.
- A soft_rst pulse is acted on in the same cycle it is sampled; a pulse held for N cycles keeps the block in GTX_RST with cnt=0 throughout.

## Test plan
- Clean bring-up: set C_STABLE_CYCLES=8 and C_GTXRST_CYCLES=4; hold plllkdet, dcm_locked and resetdone high from reset. Required: gtxreset high for 5 cycles; ready=1 at cycle 5+8+2; retry_cnt=0.
- PLL glitch during WAIT_PLL: drop plllkdet for 1 cycle at stable count 5. Required: cnt restarts; ready is delayed by 6 or more cycles; no retry.
- Lock loss in READY: drop dcm_locked for 1 cycle. Required: 3 cycles later gtxreset=1 and ready=0; retry_cnt=1; the sequence completes again afterwards.
- Timeout: set C_TIMEOUT_CYCLES=32 and hold resetdone=0. Required: a restart every 32+C_GTXRST_CYCLES cycles; retry_cnt increments and saturates at 255 after 255 loops.
- Soft reset in READY: pulse soft_rst for 1 cycle. Required: gtxreset=1 on the next cycle; retry_cnt unchanged; ready returns.
- Async reset mid-sequence: assert rst_n low while in WAIT_DONE. Required: all outputs take their reset values immediately, with no clock edge needed; retry_cnt=0.
